// File: rtl/cluster_task_dispatch.sv
// Cluster task dispatcher: hands upstream tasks to idle cores round-robin and
// funnels core completions back to the scheduler through a small feedback FIFO.
package cluster_task_dispatch_pkg;
    typedef struct packed {
        logic [7:0]  handler_id;
        logic [23:0] arg;
    } handler_task_t;

    typedef struct packed {
        logic [7:0] handler_id;
        logic [7:0] status;
    } feedback_descr_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKED  = 2'd2
    } dispatch_state_e;
endpackage

module cluster_task_dispatch
    import cluster_task_dispatch_pkg::*;
#(
    parameter int NUM_CORES = 8,
    parameter int FB_DEPTH  = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 task_valid_i,
    output logic                                 task_ready_o,
    input  handler_task_t                        task_descr_i,
    output logic [NUM_CORES-1:0]                 core_task_valid_o,
    input  logic [NUM_CORES-1:0]                 core_task_ready_i,
    output handler_task_t                        core_task_descr_o,
    input  logic [NUM_CORES-1:0]                 core_done_valid_i,
    output logic [NUM_CORES-1:0]                 core_done_ready_o,
    input  feedback_descr_t [NUM_CORES-1:0]      core_done_i,
    output logic                                 feedback_valid_o,
    input  logic                                 feedback_ready_i,
    output feedback_descr_t                      feedback_o,
    output logic [$clog2(NUM_CORES):0]           busy_cores_o,
    output dispatch_state_e                      state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid holder keeps valid and payload stable until that edge.

    localparam int IW = $clog2(NUM_CORES);
    localparam int BW = IW + 1;
    localparam int PW = $clog2(FB_DEPTH);
    localparam int CW = PW + 1;

    // Returns {found, index} of the first set bit of req at or above ptr, wrapping.
    function automatic logic [IW:0] pick(input logic [NUM_CORES-1:0] req,
                                         input logic [IW-1:0]        ptr);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            idx = ptr + IW'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    dispatch_state_e  state_q, state_d;
    handler_task_t    task_q;
    logic [IW-1:0]    locked_q, rr_ptr_q, arb_ptr_q;
    logic [NUM_CORES-1:0] busy_q, busy_d;

    feedback_descr_t  fifo_q [FB_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic [IW:0]      sel, grant;
    logic             sel_found, grant_any, fifo_full, fifo_empty, push, pop;
    logic [IW-1:0]    sel_idx, grant_idx;
    logic             load_task, lock, fire;

    assign sel       = pick(~busy_q, rr_ptr_q);
    assign sel_found = sel[IW];
    assign sel_idx   = sel[IW-1:0];

    assign fifo_full  = (count_q == CW'(FB_DEPTH));
    assign fifo_empty = (count_q == '0);

    // A full FIFO blocks grants even when the head pops this cycle.
    assign grant     = pick(core_done_valid_i, arb_ptr_q);
    assign grant_idx = grant[IW-1:0];
    assign grant_any = grant[IW] & ~fifo_full & rst_ni;
    assign push      = grant_any;
    assign pop       = ~fifo_empty & feedback_ready_i;

    assign feedback_valid_o  = ~fifo_empty;
    assign feedback_o        = fifo_q[rd_ptr_q];
    assign core_task_descr_o = task_q;
    assign state_o           = state_q;

    always_comb begin
        core_done_ready_o = '0;
        if (grant_any) core_done_ready_o[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d           = state_q;
        task_ready_o      = 1'b0;
        core_task_valid_o = '0;
        load_task         = 1'b0;
        lock              = 1'b0;
        fire              = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                task_ready_o = 1'b1;
                if (task_valid_i) begin
                    load_task = 1'b1;
                    // An idle core is locked right away so the offer goes out next cycle.
                    if (sel_found) begin
                        lock    = 1'b1;
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (sel_found) begin
                    lock    = 1'b1;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                task_ready_o                = core_task_ready_i[locked_q];
                core_task_valid_o[locked_q] = 1'b1;
                if (core_task_ready_i[locked_q]) begin
                    fire = 1'b1;
                    if (task_valid_i) begin
                        load_task = 1'b1;
                        state_d   = ST_PENDING;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (!rst_ni) begin
            task_ready_o      = 1'b1;
            core_task_valid_o = '0;
        end
    end

    // Completion clears first; a dispatch in the same cycle to that core wins.
    always_comb begin
        busy_d = busy_q;
        if (grant_any) busy_d[grant_idx] = 1'b0;
        if (fire)      busy_d[locked_q]  = 1'b1;
    end

    always_comb begin
        busy_cores_o = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            busy_cores_o = busy_cores_o + BW'(busy_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_EMPTY;
            task_q    <= '0;
            locked_q  <= '0;
            rr_ptr_q  <= '0;
            arb_ptr_q <= '0;
            busy_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            if (load_task) task_q    <= task_descr_i;
            if (lock)      locked_q  <= sel_idx;
            if (fire)      rr_ptr_q  <= locked_q + IW'(1);
            if (grant_any) arb_ptr_q <= grant_idx + IW'(1);
            if (push)      wr_ptr_q  <= wr_ptr_q + PW'(1);
            if (pop)       rd_ptr_q  <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= core_done_i[grant_idx];
    end

endmodule

// File: doc/cluster_task_dispatch.md
CLUSTER_TASK_DISPATCH -- requirements
Module: cluster_task_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 8, number of handler cores in the cluster (power of two, >=2).
REQ-002 Parameter FB_DEPTH, default 4, depth of the completion-feedback FIFO (power of two, >=2).
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous and active-low.
REQ-005 task_valid_i  input  1  task offered by the upstream scheduler.
REQ-006 task_ready_o  output  1  task accepted when task_valid_i & task_ready_o.
REQ-007 task_descr_i  input  handler_task_t  incoming task descriptor.
REQ-008 core_task_valid_o  output  NUM_CORES  one-hot task offer to cores.
REQ-009 core_task_ready_i  input  NUM_CORES  per-core task acceptance.
REQ-010 core_task_descr_o  output  handler_task_t  descriptor shared by all cores.
REQ-011 core_done_valid_i  input  NUM_CORES  per-core completion offer.
REQ-012 core_done_ready_o  output  NUM_CORES  per-core completion grant, at most one hot.
REQ-013 core_done_i  input  NUM_CORES x feedback_descr_t  per-core completion descriptor.
REQ-014 feedback_valid_o  output  1  feedback to upstream scheduler valid.
REQ-015 feedback_ready_i  input  1  upstream accepts feedback.
REQ-016 feedback_o  output  feedback_descr_t  FIFO head descriptor.
REQ-017 busy_cores_o  output  clog2(NUM_CORES)+1  number of cores currently holding a task.

Function
REQ-018 Dispatch FSM SHALL have states EMPTY (no task held), PENDING (task held, no core locked), LOCKED (core locked, offer outstanding).
REQ-019 task_ready_o SHALL be 1 in EMPTY, 0 in PENDING, and in LOCKED equal to core_task_ready_i[locked core].
REQ-020 Accepted task SHALL be registered; core_task_descr_o SHALL be the registered task; earliest core offer is the cycle after acceptance.
REQ-021 In PENDING, if any core has busy=0, the block SHALL select the first idle core searching from rr_ptr upward with wrap at NUM_CORES, lock it, and go to LOCKED; else remain PENDING.
REQ-022 core_task_valid_o[locked core] SHALL be 1 only in LOCKED; selection SHALL NOT change while LOCKED.
REQ-023 On core_task_valid_o[k] & core_task_ready_i[k]: busy[k] SHALL set, rr_ptr SHALL become (k+1) mod NUM_CORES, state SHALL go to PENDING if a new task is accepted the same cycle, else EMPTY.
REQ-024 Feedback arbiter SHALL round-robin among cores with core_done_valid_i=1, granting one core per cycle only when the FIFO is not full; grant pointer advances past the granted core.
REQ-025 On grant to core j, core_done_i[j] SHALL be pushed to the FIFO and busy[j] SHALL clear.
REQ-026 Completion from a core with busy=0 SHALL still be forwarded; busy stays 0.
REQ-027 FIFO full: no core_done_ready_o asserted even if a pop occurs the same cycle; FIFO empty: feedback_valid_o=0.
REQ-028 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged; pointers SHALL wrap at FB_DEPTH.
REQ-029 feedback_o SHALL stay stable while feedback_valid_o=1 and feedback_ready_i=0.
REQ-030 busy_cores_o SHALL equal popcount(busy), registered-state derived (no input combinational path).
REQ-031 A core cleared by feedback in cycle n SHALL be selectable in PENDING in cycle n+1.

Reset
REQ-032 While rst_ni=0 at a clock edge: state=EMPTY, busy=0, rr_ptr=0, arbiter pointer=0, FIFO empty, task register cleared.
REQ-033 During/after reset: task_ready_o=1, core_task_valid_o=0, core_done_ready_o=0, feedback_valid_o=0, busy_cores_o=0; in-flight tasks and feedback are discarded.

Verification
REQ-034 One task, all cores ready -> core_task_valid_o=8'b0000_0001 one cycle after accept; busy_cores_o=1; next task goes to core 1.
REQ-035 Eight tasks, no completions, ninth offered -> ninth accepted, state stays PENDING, task_ready_o=0, busy_cores_o=8; core 3 completes -> ninth dispatched to core 3.
REQ-036 Core 2 holds core_task_ready_i=0 for 5 cycles -> core_task_valid_o=8'b0000_0100 stable 5 cycles, task_ready_o=0 until the fire cycle.
REQ-037 Cores 0,1,2 complete same cycle, feedback_ready_i=1 -> feedback_o order core 0,1,2 on three consecutive cycles; busy clears accordingly.
REQ-038 feedback_ready_i=0, 6 completions, FB_DEPTH=4 -> exactly 4 granted, 2 held pending; releasing ready drains all 6 in order.
REQ-039 rst_ni=0 with 3 busy cores, FIFO holding 2 -> next cycle busy_cores_o=0, feedback_valid_o=0, task_ready_o=1.
